// File: rtl/spike_event_arbiter_if.sv
// rtl/spike_event_arbiter_if.sv - merged event output stream between spike_event_arbiter and its consumer
interface spike_event_arbiter_if #(
  parameter int CH_W = 2
);
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [31:0]     out_event;
  logic [31:0]     out_ts;

  // Arbiter side: drives the event, receives the accept.
  modport master (
    output out_valid,
    output out_ch,
    output out_event,
    output out_ts,
    input  out_ready
  );

  // Consumer side: packetiser or host link.
  modport slave (
    input  out_valid,
    input  out_ch,
    input  out_event,
    input  out_ts,
    output out_ready
  );
endinterface

// File: rtl/spike_event_arbiter.sv
// rtl/spike_event_arbiter.sv - round-robin merge of per-channel spike events; optional timestamps via SPIKE_ARB_TIMESTAMP_EN
module spike_event_arbiter #(
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH*32-1:0]     ch_event,
  spike_event_arbiter_if.master  bus,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic [N_CH-1:0]        pend
);

  // Holding slots, one per channel.
  logic [N_CH-1:0]   pend_q;
  logic [31:0]       slot_event [N_CH];

  // Registered output stage.
  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [31:0]       out_event_q;

  logic [CH_W-1:0]   last_grant;
  logic [DROP_W-1:0] drop_cnt_q;

  // Per-cycle decisions.
  logic              loadable;
  logic              gnt_any;
  logic              do_grant;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   cand;
  logic [N_CH-1:0]   gnt_vec;
  logic [N_CH-1:0]   cap_vec;
  logic [N_CH-1:0]   drop_vec;
  logic [CH_W:0]     drop_num;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_next;

  // The output register may take a new event when empty or being accepted this cycle.
  assign loadable = !out_valid_q || bus.out_ready;
  assign do_grant = loadable && gnt_any;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(last_grant) + k) % N_CH);
      if (!gnt_any && pend_q[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A slot being drained this cycle is free to take a new event, so it never drops.
  always_comb begin
    gnt_vec  = '0;
    cap_vec  = '0;
    drop_vec = '0;
    drop_num = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt_vec[i]  = do_grant && (gnt_idx == CH_W'(i));
      cap_vec[i]  = ch_valid[i] && (!pend_q[i] || gnt_vec[i]);
      drop_vec[i] = ch_valid[i] && pend_q[i] && !gnt_vec[i];
      drop_num    = drop_num + {{CH_W{1'b0}}, drop_vec[i]};
    end
  end

  // Saturating drop total; one spare bit catches the overflow.
  always_comb begin
    drop_sum  = {1'b0, drop_cnt_q} + (DROP_W+1)'(drop_num);
    drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Slot occupancy, slot contents, output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_event_q <= '0;
      last_grant  <= CH_W'(N_CH - 1);
      drop_cnt_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        slot_event[i] <= '0;
      end
    end else begin
      pend_q     <= cap_vec | (pend_q & ~gnt_vec);
      drop_cnt_q <= drop_next;
      for (int i = 0; i < N_CH; i++) begin
        if (cap_vec[i]) begin
          slot_event[i] <= ch_event[32*i +: 32];
        end
      end
      if (do_grant) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= gnt_idx;
        out_event_q <= slot_event[gnt_idx];
        last_grant  <= gnt_idx;
      end else if (loadable) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef SPIKE_ARB_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] slot_ts [N_CH];
  logic [31:0] out_ts_q;

  // Free-running capture clock, per-slot capture time and its output copy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_cnt   <= '0;
      out_ts_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        slot_ts[i] <= '0;
      end
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      for (int i = 0; i < N_CH; i++) begin
        if (cap_vec[i]) begin
          slot_ts[i] <= ts_cnt;
        end
      end
      if (do_grant) begin
        out_ts_q <= slot_ts[gnt_idx];
      end
    end
  end

  assign bus.out_ts = out_ts_q;
`else
  assign bus.out_ts = 32'd0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_event = out_event_q;
  assign drop_cnt      = drop_cnt_q;
  assign pend          = pend_q;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// tb/tb_spike_event_arbiter.sv - scenario and randomized checks of spike_event_arbiter against a slot/queue model
module tb_spike_event_arbiter;
  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N_CH-1:0]     ch_valid;
  logic [N_CH*32-1:0]  ch_event;
  logic [15:0]         drop_a;
  logic [3:0]          drop_b;
  logic [N_CH-1:0]     pend_a;
  logic [N_CH-1:0]     pend_b;

  spike_event_arbiter_if #(.CH_W(CH_W)) bus_a ();
  spike_event_arbiter_if #(.CH_W(CH_W)) bus_b ();

  spike_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .DROP_W(16)) dut_a (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_event(ch_event),
    .bus(bus_a), .drop_cnt(drop_a), .pend(pend_a)
  );

  spike_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .DROP_W(4)) dut_b (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_event(ch_event),
    .bus(bus_b), .drop_cnt(drop_b), .pend(pend_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a set of free/full slots, an output holder and a pointer.
  logic [N_CH-1:0] m_pend;
  logic [31:0]     m_slot [N_CH];
  logic [31:0]     m_sts  [N_CH];
  int              m_last;
  logic            m_ov;
  logic [CH_W-1:0] m_oc;
  logic [31:0]     m_oe;
  logic [31:0]     m_ots;
  int              m_drops;
  logic [31:0]     m_tsc;
  logic [31:0]     delivered [$];

  task automatic model_step(input logic [N_CH-1:0] v, input logic [N_CH*32-1:0] ev,
                            input logic rdy, input logic r);
    int  g;
    logic ld;
    if (!r) begin
      m_pend = '0; m_ov = 1'b0; m_oc = '0; m_oe = '0; m_ots = '0;
      m_drops = 0; m_tsc = '0; m_last = N_CH - 1;
      return;
    end
    ld = !m_ov || rdy;
    g  = -1;
    if (ld) begin
      for (int k = 1; k <= N_CH; k++) begin
        int c = (m_last + k) % N_CH;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      m_ov = 1'b1; m_oc = g[CH_W-1:0]; m_oe = m_slot[g]; m_ots = m_sts[g];
      m_last = g; m_pend[g] = 1'b0;
    end else if (ld) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) begin
        if (!m_pend[i]) begin
          m_slot[i] = ev[32*i +: 32];
          m_sts[i]  = m_tsc;
          m_pend[i] = 1'b1;
        end else begin
          m_drops++;
        end
      end
    end
    m_tsc = m_tsc + 32'd1;
  endtask

  // One clock cycle: drive inputs, log any accepted event, advance the model, settle.
  task automatic step(input logic [N_CH-1:0] v, input logic [N_CH*32-1:0] ev,
                      input logic rdy, input logic r);
    rst = r; ch_valid = v; ch_event = ev;
    bus_a.out_ready = rdy; bus_b.out_ready = rdy;
    if (r && bus_a.out_valid && rdy) delivered.push_back(bus_a.out_event);
    model_step(v, ev, rdy, r);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_CH*32-1:0] rand_ev();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    step('0, '0, 1'b1, 1'b0);
    delivered.delete();
  endtask

  task automatic test_reset();
    step(4'hF, rand_ev(), 1'b1, 1'b0);
    step(4'hF, rand_ev(), 1'b1, 1'b0);
    total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_a.out_valid); end
    total++; if (bus_a.out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", bus_a.out_ch); end
    total++; if (bus_a.out_event !== 32'd0) begin bad++; $display("FAIL reset_event got=%h exp=0", bus_a.out_event); end
    total++; if (bus_a.out_ts !== 32'd0) begin bad++; $display("FAIL reset_ts got=%h exp=0", bus_a.out_ts); end
    total++; if (pend_a !== 4'h0) begin bad++; $display("FAIL reset_pend got=%b exp=0000", pend_a); end
    total++; if (drop_a !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_a); end
  endtask

  task automatic test_single_event();
    logic [N_CH*32-1:0] ev;
    do_reset();
    for (int c = 0; c < 5; c++) step('0, '0, 1'b1, 1'b1);
    ev = '0; ev[63:32] = 32'd3;
    step(4'b0010, ev, 1'b1, 1'b1);
    total++; if (pend_a !== 4'b0010) begin bad++; $display("FAIL single_pend got=%b exp=0010", pend_a); end
    total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", bus_a.out_valid); end
    step('0, '0, 1'b1, 1'b1);
    total++; if (bus_a.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus_a.out_valid); end
    total++; if (bus_a.out_ch !== 2'd1) begin bad++; $display("FAIL single_ch got=%0d exp=1", bus_a.out_ch); end
    total++; if (bus_a.out_event !== 32'd3) begin bad++; $display("FAIL single_event got=%h exp=3", bus_a.out_event); end
`ifdef SPIKE_ARB_TIMESTAMP_EN
    total++; if (bus_a.out_ts !== 32'd5) begin bad++; $display("FAIL single_ts got=%0d exp=5", bus_a.out_ts); end
`else
    total++; if (bus_a.out_ts !== 32'd0) begin bad++; $display("FAIL single_ts got=%0d exp=0", bus_a.out_ts); end
`endif
  endtask

  task automatic test_fairness();
    logic [N_CH*32-1:0] ev;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      ev = '0;
      for (int i = 0; i < N_CH; i++) ev[32*i +: 32] = 32'(c * 16 + i);
      step((c % 4 == 0 && c < 8) ? 4'hF : 4'h0, ev, 1'b1, 1'b1);
      if (c >= 1) begin
        total++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_ch !== 2'((c - 1) % 4)) begin
          bad++; $display("FAIL fair_ch cycle=%0d got=%0d/%b exp=%0d/1", c, bus_a.out_ch, bus_a.out_valid, (c - 1) % 4);
        end
      end
    end
    total++; if (drop_a !== 16'd0) begin bad++; $display("FAIL fair_drop got=%0d exp=0", drop_a); end
  endtask

  task automatic test_backpressure();
    logic [N_CH*32-1:0] ev;
    logic               seen_b;
    do_reset();
    ev = '0; ev[63:32] = 32'h55;
    step(4'b0010, ev, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    for (int c = 2; c < 5; c++) begin
      ev = '0; ev[31:0] = (c == 2) ? 32'hA : 32'hB;
      step((c == 3) ? 4'b0000 : 4'b0001, ev, 1'b0, 1'b1);
      total++; if (bus_a.out_event !== 32'h55 || bus_a.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold cycle=%0d got=%h exp=55", c, bus_a.out_event);
      end
    end
    total++; if (pend_a[0] !== 1'b1) begin bad++; $display("FAIL bp_pend got=%b exp=1", pend_a[0]); end
    total++; if (drop_a !== 16'd1) begin bad++; $display("FAIL bp_drop got=%0d exp=1", drop_a); end
    for (int c = 0; c < 4; c++) step('0, '0, 1'b1, 1'b1);
    total++; if (delivered.size() != 2 || delivered[0] !== 32'h55 || delivered[1] !== 32'hA) begin
      bad++; $display("FAIL bp_order got=%0d items exp=55,A", delivered.size());
    end
    seen_b = 1'b0;
    foreach (delivered[j]) if (delivered[j] === 32'hB) seen_b = 1'b1;
    total++; if (seen_b !== 1'b0) begin bad++; $display("FAIL bp_no_b got=%b exp=0", seen_b); end
  endtask

  task automatic test_recapture();
    logic [N_CH*32-1:0] ev;
    do_reset();
    ev = '0; ev[95:64] = 32'hE1;
    step(4'b0100, ev, 1'b1, 1'b1);
    ev = '0; ev[95:64] = 32'hE2;
    step(4'b0100, ev, 1'b1, 1'b1);
    total++; if (pend_a[2] !== 1'b1) begin bad++; $display("FAIL recap_pend got=%b exp=1", pend_a[2]); end
    for (int c = 0; c < 3; c++) step('0, '0, 1'b1, 1'b1);
    total++; if (delivered.size() != 2 || delivered[0] !== 32'hE1 || delivered[1] !== 32'hE2) begin
      bad++; $display("FAIL recap_order got=%0d items exp=E1,E2", delivered.size());
    end
    total++; if (drop_a !== 16'd0) begin bad++; $display("FAIL recap_drop got=%0d exp=0", drop_a); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 7; c++) step(4'hF, rand_ev(), 1'b0, 1'b1);
    total++; if (drop_a !== 16'd23) begin bad++; $display("FAIL sat_wide got=%0d exp=23", drop_a); end
    total++; if (drop_b !== 4'd15) begin bad++; $display("FAIL sat_narrow got=%0d exp=15", drop_b); end
    for (int c = 0; c < 3; c++) step(4'hF, rand_ev(), 1'b0, 1'b1);
    total++; if (drop_a !== 16'd35) begin bad++; $display("FAIL sat_wide2 got=%0d exp=35", drop_a); end
    total++; if (drop_b !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", drop_b); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(4'hF, rand_ev(), 1'b0, 1'b1);
    step(4'hF, rand_ev(), 1'b0, 1'b1);
    total++; if (bus_a.out_valid !== 1'b1 || pend_a !== 4'hF) begin
      bad++; $display("FAIL mid_pre got=%b/%b exp=1/1111", bus_a.out_valid, pend_a);
    end
    step(4'hF, rand_ev(), 1'b0, 1'b0);
    total++; if (bus_a.out_valid !== 1'b0 || bus_a.out_ch !== 2'd0 || bus_a.out_event !== 32'd0 || bus_a.out_ts !== 32'd0) begin
      bad++; $display("FAIL mid_out got=%b/%0d/%h/%h exp=0/0/0/0", bus_a.out_valid, bus_a.out_ch, bus_a.out_event, bus_a.out_ts);
    end
    total++; if (pend_a !== 4'h0 || drop_a !== 16'd0) begin
      bad++; $display("FAIL mid_state got=%b/%0d exp=0000/0", pend_a, drop_a);
    end
    step(4'b1001, rand_ev(), 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1);
    total++; if (bus_a.out_valid !== 1'b1 || bus_a.out_ch !== 2'd0) begin
      bad++; $display("FAIL mid_first got=%0d/%b exp=0/1", bus_a.out_ch, bus_a.out_valid);
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] v;
    logic [15:0]     exp_a;
    logic [3:0]      exp_b;
    logic [31:0]     exp_ts;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_CH; i++) v[i] = ($urandom_range(0, 2) == 0);
      step(v, rand_ev(), ($urandom_range(0, 3) != 0), 1'b1);
      exp_a = (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
      exp_b = (m_drops > 15) ? 4'hF : 4'(m_drops);
`ifdef SPIKE_ARB_TIMESTAMP_EN
      exp_ts = m_ots;
`else
      exp_ts = 32'd0;
`endif
      total++; if (bus_a.out_valid !== m_ov) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus_a.out_valid, m_ov); end
      total++; if (bus_a.out_ch !== m_oc) begin bad++; $display("FAIL rnd_ch c=%0d got=%0d exp=%0d", c, bus_a.out_ch, m_oc); end
      total++; if (bus_a.out_event !== m_oe) begin bad++; $display("FAIL rnd_event c=%0d got=%h exp=%h", c, bus_a.out_event, m_oe); end
      total++; if (bus_a.out_ts !== exp_ts) begin bad++; $display("FAIL rnd_ts c=%0d got=%h exp=%h", c, bus_a.out_ts, exp_ts); end
      total++; if (pend_a !== m_pend) begin bad++; $display("FAIL rnd_pend c=%0d got=%b exp=%b", c, pend_a, m_pend); end
      total++; if (drop_a !== exp_a) begin bad++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop_a, exp_a); end
      total++; if (drop_b !== exp_b) begin bad++; $display("FAIL rnd_drop4 c=%0d got=%0d exp=%0d", c, drop_b, exp_b); end
      total++; if (bus_b.out_valid !== m_ov || bus_b.out_ch !== m_oc || bus_b.out_event !== m_oe || bus_b.out_ts !== exp_ts || pend_b !== m_pend) begin
        bad++; $display("FAIL rnd_b c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus_b.out_valid, bus_b.out_ch, bus_b.out_event, m_ov, m_oc, m_oe);
      end
    end
  endtask

  initial begin
    rst = 1'b0; ch_valid = '0; ch_event = '0;
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
    test_reset();
    test_single_event();
    test_fairness();
    test_backpressure();
    test_recapture();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
